// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache; one line transaction at a time.
// Request reaches the bus 1 cycle after grant, ack/data return 1 cycle after mem_ack_i; owners hold req until ack.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    input  logic              icache_kill_i,
    output logic              icache_ack_o,
    output logic [LINE_W-1:0] icache_data_o,
    input  logic              dcache_req_i,
    input  logic              dcache_wr_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic [LINE_W-1:0] dcache_wdata_i,
    input  logic              dcache_kill_i,
    output logic              dcache_ack_o,
    output logic [LINE_W-1:0] dcache_data_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_d;
    logic                r_killed;
    logic                r_mem_req;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;
    logic                r_icache_ack;
    logic                r_dcache_ack;
    logic [LINE_W-1:0]   r_icache_data;
    logic [LINE_W-1:0]   r_dcache_data;

    logic w_idle;
    logic w_busy;
    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;
    logic w_owner_kill;
    logic w_deliver;

    assign w_idle    = (r_state == IDLE);
    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_i_elig  = icache_req_i && !icache_kill_i;
    assign w_d_elig  = dcache_req_i && !dcache_kill_i;
    // On a tie the side that did not win last time gets the grant
    assign w_grant_i = w_idle && w_i_elig && (!w_d_elig || r_last_d);
    assign w_grant_d = w_idle && w_d_elig && !w_grant_i;

    assign w_owner_kill = ((r_state == BUSY_I) && icache_kill_i) ||
                          ((r_state == BUSY_D) && dcache_kill_i);
    // A kill landing in the ack cycle itself still abandons the transaction
    assign w_deliver    = w_busy && mem_ack_i && !(r_killed || w_owner_kill);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_i) begin
                    w_next = BUSY_I;
                end else if (w_grant_d) begin
                    w_next = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack_i) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d      <= 1'b1;
            r_killed      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_icache_ack  <= 1'b0;
            r_dcache_ack  <= 1'b0;
            r_icache_data <= '0;
            r_dcache_data <= '0;
        end else begin
            r_icache_ack <= w_deliver && (r_state == BUSY_I);
            r_dcache_ack <= w_deliver && (r_state == BUSY_D);
            if (w_deliver && (r_state == BUSY_I)) begin
                r_icache_data <= mem_rdata_i;
            end
            if (w_deliver && (r_state == BUSY_D)) begin
                r_dcache_data <= mem_rdata_i;
            end

            if (w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_wr    <= 1'b0;
                r_mem_addr  <= icache_addr_i;
                r_mem_wdata <= '0;
                r_last_d    <= 1'b0;
            end else if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_wr    <= dcache_wr_i;
                r_mem_addr  <= dcache_addr_i;
                r_mem_wdata <= dcache_wdata_i;
                r_last_d    <= 1'b1;
            end else if (w_busy && mem_ack_i) begin
                r_mem_req <= 1'b0;
                r_mem_wr  <= 1'b0;
            end

            if (w_busy && w_owner_kill) begin
                r_killed <= 1'b1;
            end else if (r_state == DONE) begin
                r_killed <= 1'b0;
            end
        end
    end

    assign icache_ack_o  = r_icache_ack;
    assign icache_data_o = r_icache_data;
    assign dcache_ack_o  = r_dcache_ack;
    assign dcache_data_o = r_dcache_data;
    assign mem_req_o     = r_mem_req;
    assign mem_wr_o      = r_mem_wr;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter with scoreboard queues for bus requests and acks.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         icache_req_i;
    logic [31:0]  icache_addr_i;
    logic         icache_kill_i;
    logic         icache_ack_o;
    logic [127:0] icache_data_o;
    logic         dcache_req_i;
    logic         dcache_wr_i;
    logic [31:0]  dcache_addr_i;
    logic [127:0] dcache_wdata_i;
    logic         dcache_kill_i;
    logic         dcache_ack_o;
    logic [127:0] dcache_data_o;
    logic         mem_req_o;
    logic         mem_wr_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [127:0] mem_rdata_i;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_req_i  (icache_req_i),
        .icache_addr_i (icache_addr_i),
        .icache_kill_i (icache_kill_i),
        .icache_ack_o  (icache_ack_o),
        .icache_data_o (icache_data_o),
        .dcache_req_i  (dcache_req_i),
        .dcache_wr_i   (dcache_wr_i),
        .dcache_addr_i (dcache_addr_i),
        .dcache_wdata_i(dcache_wdata_i),
        .dcache_kill_i (dcache_kill_i),
        .dcache_ack_o  (dcache_ack_o),
        .dcache_data_o (dcache_data_o),
        .mem_req_o     (mem_req_o),
        .mem_wr_o      (mem_wr_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } bus_t;

    typedef struct packed {
        logic         who_d;
        logic [127:0] data;
    } ack_t;

    bus_t exp_bus[$];
    ack_t exp_ack[$];

    int   total = 0;
    int   bad   = 0;
    bit   pend_i = 0;
    bit   pend_d = 0;
    bit   last_d = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_kill(input bit to_d);
        if (to_d) dcache_kill_i = 1'b1;
        else      icache_kill_i = 1'b1;
    endtask

    task automatic drop_req(input bit from_d);
        if (from_d) begin
            dcache_req_i = 1'b0;
            pend_d       = 0;
        end else begin
            icache_req_i = 1'b0;
            pend_i       = 0;
        end
    endtask

    // One arbitration round; entered with the arbiter in IDLE at the next rising edge.
    task automatic round(input bit ni, input bit nd, input logic [31:0] ai, input logic [31:0] ad,
                         input bit wd, input logic [127:0] wdat, input bit ki, input bit kd,
                         input int kc, input int lat, input logic [127:0] rd,
                         input bit xack, input bit drop, input bit nok);
        bit el_i, el_d, win_d, any, killed;
        if (ni && !pend_i) begin
            pend_i        = 1;
            icache_addr_i = ai;
        end
        if (nd && !pend_d) begin
            pend_d         = 1;
            dcache_addr_i  = ad;
            dcache_wr_i    = wd;
            dcache_wdata_i = wdat;
        end
        icache_req_i  = pend_i;
        dcache_req_i  = pend_d;
        icache_kill_i = ki;
        dcache_kill_i = kd;
        el_i  = pend_i && !ki;
        el_d  = pend_d && !kd;
        any   = el_i || el_d;
        win_d = (el_i && el_d) ? !last_d : el_d;
        if (any) begin
            if (win_d) exp_bus.push_back('{dcache_wr_i, dcache_addr_i, dcache_wdata_i});
            else       exp_bus.push_back('{1'b0, icache_addr_i, 128'd0});
        end
        @(posedge clk); #1;
        icache_kill_i = 1'b0;
        dcache_kill_i = 1'b0;
        if (ki && pend_i) drop_req(1'b0);
        if (kd && pend_d) drop_req(1'b1);
        chk("req_rise", 512'(mem_req_o), 512'(any));
        if (!any) begin
            @(posedge clk); #1;
            return;
        end
        last_d = win_d;
        for (int c = 1; c <= lat; c++) begin
            if (c == kc) set_kill(win_d);
            if (c == 1 && nok) set_kill(!win_d);
            if (c == 1 && drop) drop_req(win_d);
            @(posedge clk); #1;
            icache_kill_i = 1'b0;
            dcache_kill_i = 1'b0;
        end
        if (kc == lat + 1) set_kill(win_d);
        killed      = (kc >= 1) && (kc <= lat + 1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        if (!killed) exp_ack.push_back('{win_d, rd});
        @(posedge clk); #1;
        icache_kill_i = 1'b0;
        dcache_kill_i = 1'b0;
        drop_req(win_d);
        chk("req_fall", 512'(mem_req_o), 512'(0));
        mem_ack_i   = xack;
        mem_rdata_i = rnd_line();
        @(posedge clk); #1;
        mem_ack_i   = 1'b0;
    endtask

    initial begin
        logic [160:0] prev_bus;
        logic         prev_req;
        logic [127:0] prev_idata, prev_ddata;
        bus_t         eb;
        ack_t         ea;
        int           lat, kc;

        rst = 1'b1;
        icache_req_i = 0; icache_addr_i = 0; icache_kill_i = 0;
        dcache_req_i = 0; dcache_wr_i = 0; dcache_addr_i = 0; dcache_wdata_i = 0; dcache_kill_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        prev_bus = 0; prev_req = 0; prev_idata = 0; prev_ddata = 0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (mem_req_o && !prev_req) begin
                        if (exp_bus.size() == 0) begin
                            chk("bus_unexpected", 512'(mem_req_o), 512'(0));
                        end else begin
                            eb = exp_bus.pop_front();
                            chk("bus_issue", 512'({mem_wr_o, mem_addr_o, mem_wdata_o}), 512'(eb));
                        end
                    end else if (mem_req_o) begin
                        chk("bus_stable", 512'({mem_wr_o, mem_addr_o, mem_wdata_o}), 512'(prev_bus));
                    end
                    if (!mem_req_o) chk("wr_idle", 512'(mem_wr_o), 512'(0));
                    if (icache_ack_o || dcache_ack_o) begin
                        if (exp_ack.size() == 0) begin
                            chk("ack_unexpected", 512'({icache_ack_o, dcache_ack_o}), 512'(0));
                        end else begin
                            ea = exp_ack.pop_front();
                            chk("ack_owner", 512'({icache_ack_o, dcache_ack_o}),
                                512'(ea.who_d ? 2'b01 : 2'b10));
                            chk("ack_data", 512'(ea.who_d ? dcache_data_o : icache_data_o), 512'(ea.data));
                        end
                    end
                    if (!icache_ack_o) chk("idata_hold", 512'(icache_data_o), 512'(prev_idata));
                    if (!dcache_ack_o) chk("ddata_hold", 512'(dcache_data_o), 512'(prev_ddata));
                end
                prev_req   = mem_req_o;
                prev_bus   = {mem_wr_o, mem_addr_o, mem_wdata_o};
                prev_idata = icache_data_o;
                prev_ddata = dcache_data_o;
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 512'({icache_ack_o, icache_data_o, dcache_ack_o, dcache_data_o,
                                   mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o}), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Tie out of reset, write-back stall, alternation, busy kill, idle kill
        round(1, 1, 32'h8000_0040, 32'h8000_1000, 1, 128'hAAAAAAAAAAAAAAAA5555555555555555,
              0, 0, -1, 4, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 0, 0);
        round(0, 0, 0, 0, 0, 0, 0, 0, -1, 10, rnd_line(), 1, 0, 0);
        round(1, 1, 32'h8000_2000, 32'h8000_3000, 0, rnd_line(), 0, 0, -1, 2, rnd_line(), 0, 0, 0);
        round(1, 0, 32'h8000_4000, 0, 0, 0, 0, 0, 2, 5, rnd_line(), 0, 0, 0);
        round(0, 0, 0, 0, 0, 0, 0, 0, -1, 3, rnd_line(), 0, 0, 0);
        round(1, 1, 32'h8000_5000, 32'h8000_6000, 0, rnd_line(), 0, 1, -1, 1, rnd_line(), 0, 0, 0);

        for (int r = 0; r < 80; r++) begin
            lat = int'($urandom_range(0, 6));
            kc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat + 1)) : -1;
            round($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom & 32'hFFFF_FFF0, $urandom & 32'hFFFF_FFF0, $urandom_range(0, 1) == 1,
                  rnd_line(), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, kc, lat,
                  rnd_line(), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0);
        end

        round(0, 0, 0, 0, 0, 0, 0, 0, -1, 1, rnd_line(), 0, 0, 0);
        round(0, 0, 0, 0, 0, 0, 0, 0, -1, 1, rnd_line(), 0, 0, 0);

        // Reset in the middle of an icache transaction, then a stray late ack
        icache_addr_i = 32'h8000_7000;
        icache_req_i  = 1'b1;
        pend_i        = 1;
        exp_bus.push_back('{1'b0, 32'h8000_7000, 128'd0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 512'({icache_ack_o, icache_data_o, dcache_ack_o, dcache_data_o,
                                    mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o}), 512'(0));
        drop_req(1'b0);
        last_d = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = rnd_line();
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_req", 512'(mem_req_o), 512'(0));

        round(1, 1, 32'h8000_8000, 32'h8000_9000, 0, rnd_line(), 0, 0, -1, 2, rnd_line(), 0, 0, 0);
        round(0, 0, 0, 0, 0, 0, 0, 0, -1, 1, rnd_line(), 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("bus_queue_empty", 512'(exp_bus.size()), 512'(0));
        chk("ack_queue_empty", 512'(exp_ack.size()), 512'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single data-memory port between the instruction cache and the write-back data cache. It sits between the icache/dcache memory-side interfaces and the memory bus. It grants one cache-line transaction at a time with round-robin fairness and holds the grant until the memory acknowledges. It registers the request onto the bus, routes the acknowledgement and read data back to the owner, and drains killed transactions silently.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- LINE_W, 128, cache-line data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- icache_req_i  in  1  icache line-read request; held until icache_ack_o
- icache_addr_i  in  ADDR_W  icache line address
- icache_kill_i  in  1  abandon the icache transaction
- icache_ack_o  out  1  one-cycle completion pulse to the icache
- icache_data_o  out  LINE_W  read line; valid while icache_ack_o is high
- dcache_req_i  in  1  dcache request; held until dcache_ack_o
- dcache_wr_i  in  1  1 = line write-back, 0 = line fill
- dcache_addr_i  in  ADDR_W  dcache line address
- dcache_wdata_i  in  LINE_W  write-back line
- dcache_kill_i  in  1  abandon the dcache transaction
- dcache_ack_o  out  1  one-cycle completion pulse to the dcache
- dcache_data_o  out  LINE_W  read line; valid while dcache_ack_o is high
- mem_req_o  out  1  memory request
- mem_wr_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  LINE_W  memory write data
- mem_ack_i  in  1  memory completion
- mem_rdata_i  in  LINE_W  memory read data; valid with mem_ack_i

## Operation
- The FSM has four states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - With only one request present, that requester wins.
  - With both present, the requester that was not granted most recently wins (last_grant register).
  - A requester whose kill is high in the same cycle is not eligible.
  - The winner's address, wdata and wr are latched into the mem_* registers. mem_req_o is set, and the FSM goes to BUSY_I or BUSY_D. last_grant is updated to the winner.
  - The icache path always drives mem_wr_o = 0 and mem_wdata_o = 0.
- BUSY_x:
  - The mem_* outputs stay stable until mem_ack_i. Requester inputs are not re-sampled.
  - If the owner's kill is asserted in any BUSY cycle, a sticky killed flag is set. The bus transaction is not aborted.
  - When mem_ack_i arrives: clear mem_req_o and mem_wr_o, and go to DONE. If killed is clear, pulse the owner's ack and register mem_rdata_i into the owner's data output. If killed is set, suppress the ack and leave the data output unchanged.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - No arbitration happens in DONE. The owner drops its req in this cycle, which prevents a double issue.
  - killed is cleared.
- mem_ack_i is ignored in IDLE and DONE.
- A req that drops during BUSY without kill does not abort the transaction. The ack is still delivered.
- The non-owner's ack is never asserted.
- The non-owner's kill has no effect on the current transaction.
- Reset values:
  - All outputs 0.
  - State is IDLE.
  - last_grant = dcache, so the icache wins the first tie.
  - killed = 0.
- Reset asserted mid-transaction returns the block to IDLE immediately with mem_req_o = 0. Any later mem_ack_i is ignored.

## Timing
- A request seen in IDLE at cycle 0 gives mem_req_o = 1 from cycle 1.
- mem_ack_i sampled high at cycle N gives ack_o and data_o at cycle N+1, for exactly one cycle, with mem_req_o = 0 at N+1.
- The earliest next grant is decided in IDLE at cycle N+2, so mem_req_o is next asserted at N+3.
- Minimum transaction occupancy is 3 cycles of arbiter overhead plus the memory latency.
- Memory may hold mem_ack_i high for only one cycle. Any extra ack cycles fall in DONE or IDLE and are ignored.

## Test plan
- Single icache read, addr 0x8000_0040, memory acks 4 cycles after mem_req_o with data 0x0123…CDEF:
  - mem_req_o = 1, mem_wr_o = 0, mem_addr_o = 0x8000_0040.
  - icache_ack_o pulses once, with icache_data_o equal to the acked line.
  - dcache_ack_o stays 0.
- Both requesters assert at the same cycle out of reset:
  - The icache is granted first.
  - The dcache is granted at ack+2 in IDLE.
  - With both held continuously, grants alternate I, D, I, D over 4 transactions.
- dcache write-back, addr 0x8000_1000, wdata 0xAAAA…5555:
  - mem_wr_o = 1 and mem_wdata_o match the inputs and stay stable across a 10-cycle memory stall.
  - dcache_ack_o pulses once.
- dcache_kill_i pulsed in the 2nd BUSY_D cycle:
  - mem_req_o stays 1 until mem_ack_i.
  - dcache_ack_o never rises and dcache_data_o is unchanged.
  - A pending icache request is granted afterwards.
- rst asserted during BUSY_I, then mem_ack_i arrives 2 cycles after rst deasserts:
  - All outputs are 0, the FSM is in IDLE, and the late ack produces no requester ack.
- Requester kill high in the same IDLE cycle as its req:
  - That requester is not granted. The other requester, if present, is granted.
